video_stream_gen: RTL and testbench

- Pixel-stream transmitter: produces the vsync/hsync/clken/8-bit-Y frame stream consumed by the image-processing chain (Sobel, median, threshold stages).
- Drains pixels from an upstream line FIFO (SDRAM read side or test pattern buffer) and wraps them in frame/line timing.
- Used to replay stored frames into the processing pipeline and as the bench stimulus source for processing blocks.

---
 rtl/video_stream_gen.sv | 186 ++++++++++++++++++
 tb/tb_video_stream_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_gen.sv
// Frame/line timing wrapper that drains an upstream line FIFO into a vsync/hsync/clken/Y pixel stream.
// state     | meaning
// IDLE      | waiting for gen_en at a frame boundary
// VSYNC     | vsync high for VS_LINES line periods
// VBACK     | back porch, V_BACK line periods, all outputs low
// LINE_WAIT | waiting for a full line in the FIFO
// ACTIVE    | reading H_ACTIVE pixels
// HBLANK    | H_BLANK idle cycles after each line
// VFRONT    | front porch, V_FRONT line periods, frame_done on the last cycle
module video_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 160,
  parameter int VS_LINES = 2,
  parameter int V_BACK   = 10,
  parameter int V_FRONT  = 10,
  parameter int LVL_W    = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gen_en,
  input  logic [LVL_W-1:0] fifo_level,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_dout,
  output logic             fifo_rd_en,
  output logic             pre_frame_vsync,
  output logic             pre_frame_hsync,
  output logic             pre_frame_clken,
  output logic [7:0]       pre_img_Y,
  output logic             frame_done,
  output logic             underflow
);

  localparam int LINE_PERIOD = H_ACTIVE + H_BLANK;
  localparam int V_MAX_A = (V_ACTIVE > VS_LINES) ? V_ACTIVE : VS_LINES;
  localparam int V_MAX_B = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
  localparam int V_MAX   = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int HW = $clog2(LINE_PERIOD + 1);
  localparam int VW = $clog2(V_MAX + 1);

  localparam logic [HW-1:0]    H_ACT_LAST  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0]    H_BLK_LAST  = HW'(H_BLANK - 1);
  localparam logic [HW-1:0]    H_LINE_LAST = HW'(LINE_PERIOD - 1);
  localparam logic [VW-1:0]    VS_LAST     = VW'(VS_LINES - 1);
  localparam logic [VW-1:0]    VB_LAST     = VW'(V_BACK - 1);
  localparam logic [VW-1:0]    VA_LAST     = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0]    VF_LAST     = VW'(V_FRONT - 1);
  localparam logic [LVL_W-1:0] LVL_NEED    = LVL_W'(H_ACTIVE);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_LINE_WAIT, S_ACTIVE, S_HBLANK, S_VFRONT
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic            vsync_q, rd_en_q, line_q, pix_bad_q, frame_done_q, underflow_q;
  logic            line_ok, frame_end_d;
  state_t          line_start;

  // A line may start on the same edge a porch/blank ends, so no LINE_WAIT cycle is spent when data is ready.
  assign line_ok    = fifo_level >= LVL_NEED;
  assign line_start = line_ok ? S_ACTIVE : S_LINE_WAIT;

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (gen_en) begin
          state_d = S_VSYNC;
          h_cnt_d = '0;
          v_cnt_d = '0;
        end
      end
      S_VSYNC: begin
        if (h_cnt_q == H_LINE_LAST) begin
          h_cnt_d = '0;
          if (v_cnt_q == VS_LAST) begin
            v_cnt_d = '0;
            state_d = (V_BACK > 0) ? S_VBACK : line_start;
          end else begin
            v_cnt_d = v_cnt_q + VW'(1);
          end
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
      end
      S_VBACK: begin
        if (h_cnt_q == H_LINE_LAST) begin
          h_cnt_d = '0;
          if (v_cnt_q == VB_LAST) begin
            v_cnt_d = '0;
            state_d = line_start;
          end else begin
            v_cnt_d = v_cnt_q + VW'(1);
          end
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
      end
      S_LINE_WAIT: begin
        h_cnt_d = '0;
        if (line_ok) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (h_cnt_q == H_ACT_LAST) begin
          h_cnt_d = '0;
          state_d = S_HBLANK;
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
      end
      S_HBLANK: begin
        if (h_cnt_q == H_BLK_LAST) begin
          h_cnt_d = '0;
          if (v_cnt_q == VA_LAST) begin
            v_cnt_d = '0;
            if (V_FRONT > 0) state_d = S_VFRONT;
            else             state_d = gen_en ? S_VSYNC : S_IDLE;
          end else begin
            v_cnt_d = v_cnt_q + VW'(1);
            state_d = line_start;
          end
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
      end
      S_VFRONT: begin
        if (h_cnt_q == H_LINE_LAST) begin
          h_cnt_d = '0;
          if (v_cnt_q == VF_LAST) begin
            v_cnt_d = '0;
            state_d = gen_en ? S_VSYNC : S_IDLE;
          end else begin
            v_cnt_d = v_cnt_q + VW'(1);
          end
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with state_q.
  assign frame_end_d =
      (state_d == S_VFRONT && h_cnt_d == H_LINE_LAST && v_cnt_d == VF_LAST) ||
      ((V_FRONT == 0) && state_d == S_HBLANK && h_cnt_d == H_BLK_LAST && v_cnt_d == VA_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      vsync_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      line_q       <= 1'b0;
      pix_bad_q    <= 1'b0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      vsync_q      <= (state_d == S_VSYNC);
      rd_en_q      <= (state_d == S_ACTIVE);
      line_q       <= rd_en_q;
      pix_bad_q    <= rd_en_q & fifo_empty;
      frame_done_q <= frame_end_d;
      if (state_d == S_VSYNC && state_q != S_VSYNC) underflow_q <= 1'b0;
      else if (rd_en_q && fifo_empty)               underflow_q <= 1'b1;
    end
  end

  assign fifo_rd_en      = rd_en_q;
  assign pre_frame_vsync = vsync_q;
  assign pre_frame_hsync = line_q;
  assign pre_frame_clken = line_q;
  // An underflowed read still occupies its slot but carries a zero pixel.
  assign pre_img_Y       = (line_q && !pix_bad_q) ? fifo_dout : 8'h00;
  assign frame_done      = frame_done_q;
  assign underflow       = underflow_q;

endmodule

// File: tb/tb_video_stream_gen.sv
// Bench for video_stream_gen: FIFO model with a pixel scoreboard, table-driven frame scenarios,
// plus hand-written reset-during-line sequence.
module tb_video_stream_gen;
  localparam int LVL_W = 11;

  logic             clk = 1'b0;
  logic             rst_n, gen_en;
  logic [LVL_W-1:0] fifo_level;
  logic             fifo_empty;
  logic [7:0]       fifo_dout = 8'h00;
  logic             fifo_rd_en, pre_frame_vsync, pre_frame_hsync, pre_frame_clken;
  logic [7:0]       pre_img_Y;
  logic             frame_done, underflow;

  always #5 clk = ~clk;

  video_stream_gen #(
    .H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .VS_LINES(1), .V_BACK(1), .V_FRONT(1), .LVL_W(LVL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gen_en(gen_en),
    .fifo_level(fifo_level), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .pre_frame_vsync(pre_frame_vsync),
    .pre_frame_hsync(pre_frame_hsync), .pre_frame_clken(pre_frame_clken),
    .pre_img_Y(pre_img_Y), .frame_done(frame_done), .underflow(underflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // FIFO model and scoreboard state
  logic [7:0]       mem[$];
  logic [7:0]       exp_q[$];
  logic [7:0]       mdl_b;
  logic [7:0]       exp_b;
  int               mem_cnt = 0;
  int               rd_cnt = 0;
  int               force_idx = -1;
  logic             lvl_force = 1'b0;
  logic [LVL_W-1:0] lvl_val = '0;

  assign fifo_level = lvl_force ? lvl_val : LVL_W'(mem_cnt);
  assign fifo_empty = (mem_cnt == 0) || (force_idx >= 0 && rd_cnt == force_idx);

  // Frame monitor: working counters and a snapshot taken at frame_done
  int   cyc = 0, vs_len = 0, first_clk = -1, lines = 0, badrun = 0, nclk = 0, fdc = 0, ovl = 0, hs_run = 0;
  int   r_vs_len = 0, r_first = 0, r_lines = 0, r_badrun = 0, r_nclk = 0, r_fdc = 0, r_ovl = 0;
  logic vs_prev = 1'b0, hs_prev = 1'b0;

  always begin
    @(posedge clk);
    if (pre_frame_vsync) begin
      mem.delete();
      exp_q.delete();
      for (int i = 1; i <= 12; i++) mem.push_back(8'(i));
      mem_cnt <= 12;
      rd_cnt  <= 0;
    end else if (fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (fifo_empty) begin
        exp_q.push_back(8'h00);
        fifo_dout <= 8'hEE;
        if (mem.size() > 0) mdl_b = mem.pop_front();
      end else begin
        mdl_b = mem.pop_front();
        fifo_dout <= mdl_b;
        exp_q.push_back(mdl_b);
      end
      mem_cnt <= mem.size();
    end

    @(negedge clk);
    if (pre_frame_vsync && !vs_prev) begin
      cyc = 0; vs_len = 0; first_clk = -1; lines = 0; badrun = 0;
      nclk = 0; fdc = 0; ovl = 0; hs_run = 0;
    end else begin
      cyc++;
    end
    if (pre_frame_vsync) vs_len++;
    if (pre_frame_vsync && pre_frame_hsync) ovl++;
    if (pre_frame_hsync) begin
      hs_run++;
    end else if (hs_prev) begin
      lines++;
      if (hs_run != 4) badrun++;
      hs_run = 0;
    end
    if (pre_frame_clken || pre_frame_hsync)
      chk("clken_vs_hsync", int'(pre_frame_clken), int'(pre_frame_hsync));
    if (pre_frame_clken) begin
      nclk++;
      if (first_clk < 0) first_clk = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pixel_unexpected: actual %0d required none", pre_img_Y);
      end else begin
        exp_b = exp_q.pop_front();
        chk("pixel_y", int'(pre_img_Y), int'(exp_b));
      end
    end else begin
      chk("y_idle_zero", int'(pre_img_Y), 0);
    end
    if (frame_done) begin
      fdc++;
      r_vs_len = vs_len; r_first = first_clk; r_lines = lines; r_badrun = badrun;
      r_nclk = nclk; r_fdc = fdc; r_ovl = ovl;
    end
    vs_prev = pre_frame_vsync;
    hs_prev = pre_frame_hsync;
  end

  task automatic wait_hs(input logic lvl);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (pre_frame_hsync == lvl) break;
    end
    chk("wait_hsync", int'(pre_frame_hsync), int'(lvl));
  endtask

  task automatic start_frame(input int fidx);
    rst_n = 1'b0;
    gen_en = 1'b0;
    lvl_force = 1'b0;
    force_idx = fidx;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gen_en = 1'b1;
  endtask

  function automatic int out_vec();
    return int'({pre_frame_vsync, pre_frame_hsync, pre_frame_clken, fifo_rd_en,
                 frame_done, underflow, pre_img_Y});
  endfunction

  typedef struct {
    int stall;
    int fidx;
    bit drop;
    bit exp_uf;
    bit exp_next_vs;
    int exp_vs_len;
    int exp_first;
    int exp_lines;
    int exp_clk;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int   viol;
    tbl[0] = '{stall: 0,  fidx: -1, drop: 1'b0, exp_uf: 1'b0, exp_next_vs: 1'b1,
               exp_vs_len: 6, exp_first: 13, exp_lines: 3, exp_clk: 12};
    tbl[1] = '{stall: 20, fidx: -1, drop: 1'b0, exp_uf: 1'b0, exp_next_vs: 1'b1,
               exp_vs_len: 6, exp_first: 13, exp_lines: 3, exp_clk: 12};
    tbl[2] = '{stall: 0,  fidx: 1,  drop: 1'b0, exp_uf: 1'b1, exp_next_vs: 1'b1,
               exp_vs_len: 6, exp_first: 13, exp_lines: 3, exp_clk: 12};
    tbl[3] = '{stall: 0,  fidx: -1, drop: 1'b1, exp_uf: 1'b0, exp_next_vs: 1'b0,
               exp_vs_len: 6, exp_first: 13, exp_lines: 3, exp_clk: 12};

    rst_n = 1'b0;
    gen_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), 0);

    for (int r = 0; r < 4; r++) begin
      start_frame(tbl[r].fidx);
      if (tbl[r].stall > 0) begin
        wait_hs(1'b1);
        wait_hs(1'b0);
        lvl_force = 1'b1;
        lvl_val = LVL_W'(3);
        viol = 0;
        repeat (tbl[r].stall) begin
          @(negedge clk);
          if (fifo_rd_en || pre_frame_hsync || pre_frame_vsync) viol++;
        end
        chk("stall_quiet", viol, 0);
        lvl_force = 1'b0;
      end
      if (tbl[r].drop) begin
        wait_hs(1'b1);
        wait_hs(1'b0);
        wait_hs(1'b1);
        gen_en = 1'b0;
      end
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        if (frame_done) break;
      end
      chk("frame_done_seen", int'(frame_done), 1);
      chk("underflow_at_done", int'(underflow), int'(tbl[r].exp_uf));
      @(negedge clk);
      chk("next_vsync", int'(pre_frame_vsync), int'(tbl[r].exp_next_vs));
      chk("frame_done_width", int'(frame_done), 0);
      if (tbl[r].exp_next_vs) chk("underflow_cleared", int'(underflow), 0);
      chk("vsync_len", r_vs_len, tbl[r].exp_vs_len);
      chk("first_clken", r_first, tbl[r].exp_first);
      chk("line_count", r_lines, tbl[r].exp_lines);
      chk("clken_count", r_nclk, tbl[r].exp_clk);
      chk("bad_line_len", r_badrun, 0);
      chk("frame_done_pulses", r_fdc, 1);
      chk("vsync_hsync_overlap", r_ovl, 0);
      if (tbl[r].drop) begin
        viol = 0;
        repeat (20) begin
          @(negedge clk);
          if (pre_frame_vsync || fifo_rd_en || pre_frame_hsync) viol++;
        end
        chk("idle_after_drop", viol, 0);
      end
    end

    // Reset while a line is being read, with an underflow already flagged
    start_frame(0);
    wait_hs(1'b1);
    chk("pre_reset_underflow", int'(underflow), 1);
    chk("pre_reset_rd_en", int'(fifo_rd_en), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_line", out_vec(), 0);
    rst_n = 1'b1;
    force_idx = -1;
    @(negedge clk);
    chk("restart_vsync", int'(pre_frame_vsync), 1);
    chk("restart_underflow", int'(underflow), 0);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
